// File: rtl/src_pkg.sv
// Shared types and default sizing for the source (ingress) stream controller.
package src_pkg;

   localparam int unsigned SRC_DW_DEF    = 32;
   localparam int unsigned SRC_DEPTH_DEF = 32;

   typedef enum logic [1:0] {RECV, DRAIN, FIN, WAIT} src_state_t;

endpackage

// File: rtl/src_addr_cnt.sv
// Buffer write-address counter: clear/enable, saturates at DEPTH-1 and flags it.
module src_addr_cnt
   import src_pkg::*;
#(
   parameter int unsigned DEPTH = SRC_DEPTH_DEF
)(
   input  logic                     clk,
   input  logic                     run,
   input  logic                     i_clr,
   input  logic                     i_en,
   output logic [$clog2(DEPTH)-1:0] o_addr,
   output logic                     o_at_max
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0] r_addr;

   always_ff @(posedge clk or negedge run) begin
      if (!run) begin
         r_addr <= '0;
      end else if (i_clr) begin
         r_addr <= '0;
      end else if (i_en && !o_at_max) begin
         r_addr <= r_addr + 1'b1;
      end
   end

   assign o_addr   = r_addr;
   assign o_at_max = (r_addr == AW'(DEPTH - 1));

endmodule

// File: rtl/src_ctrl.sv
// Ingress stream controller: one frame per buffer turn, truncates overlong frames.
// Optional feature: define SRC_ERR_EN to add the sticky src_err overflow port.
module src_ctrl
   import src_pkg::*;
#(
   parameter int unsigned DW    = SRC_DW_DEF,
   parameter int unsigned DEPTH = SRC_DEPTH_DEF
)(
   input  logic                     clk,
   input  logic                     run,
   input  logic                     src_valid,
   output logic                     src_ready,
   input  logic [DW-1:0]            src_data,
   input  logic                     src_last,
   input  logic                     c_ack_in,
   output logic                     s_fin_out,
   output logic [$clog2(DEPTH):0]   frame_len,
   output logic                     stream_v,
   output logic [$clog2(DEPTH)-1:0] stream_a,
   output logic [DW-1:0]            stream_d
`ifdef SRC_ERR_EN
   ,
   output logic                     src_err
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);

   src_state_t    r_state;
   src_state_t    w_state_nxt;
   logic          r_fin;
   logic [AW:0]   r_len;
   logic [AW:0]   w_len_nxt;
   logic          w_len_ld;
   logic          w_wr;
   logic          w_clr;
   logic          w_trunc;
   logic [AW-1:0] w_addr;
   logic          w_at_max;

   src_addr_cnt #(
      .DEPTH (DEPTH)
   ) u_addr_cnt (
      .clk      (clk),
      .run      (run),
      .i_clr    (w_clr),
      .i_en     (w_wr),
      .o_addr   (w_addr),
      .o_at_max (w_at_max)
   );

   always_ff @(posedge clk or negedge run) begin
      if (!run) begin
         r_state <= RECV;
         r_fin   <= 1'b0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_fin   <= (w_state_nxt == FIN);
         if (w_len_ld) begin
            r_len <= w_len_nxt;
         end
      end
   end

   // src_ready is 1 in RECV/DRAIN, so a beat there reduces to src_valid.
   always_comb begin
      w_state_nxt = r_state;
      src_ready   = 1'b0;
      w_wr        = 1'b0;
      w_clr       = 1'b0;
      w_trunc     = 1'b0;
      w_len_ld    = 1'b0;
      w_len_nxt   = '0;
      case (r_state)
         RECV: begin
            src_ready = 1'b1;
            if (src_valid) begin
               w_wr = 1'b1;
               if (src_last) begin
                  w_state_nxt = FIN;
                  w_len_ld    = 1'b1;
                  w_len_nxt   = {1'b0, w_addr} + (AW + 1)'(1);
               end else if (w_at_max) begin
                  w_state_nxt = DRAIN;
                  w_trunc     = 1'b1;
                  w_len_ld    = 1'b1;
                  w_len_nxt   = (AW + 1)'(DEPTH);
               end
            end
         end
         DRAIN: begin
            src_ready = 1'b1;
            if (src_valid && src_last) begin
               w_state_nxt = FIN;
            end
         end
         FIN: begin
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (c_ack_in) begin
               w_state_nxt = RECV;
               w_clr       = 1'b1;
            end
         end
         default: begin
            w_state_nxt = RECV;
         end
      endcase
   end

   assign s_fin_out = r_fin;
   assign frame_len = r_len;
   assign stream_v  = w_wr;
   assign stream_a  = w_addr;
   assign stream_d  = src_data;

`ifdef SRC_ERR_EN
   logic r_err;

   always_ff @(posedge clk or negedge run) begin
      if (!run) begin
         r_err <= 1'b0;
      end else if (w_trunc) begin
         r_err <= 1'b1;
      end
   end

   assign src_err = r_err;
`endif

endmodule

// File: tb/tb_src_ctrl.sv
// Scoreboard bench for src_ctrl: driver queues expected writes/frame ends, monitor pops on output.
module tb_src_ctrl;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned AW    = 5;

   logic          clk = 1'b0;
   logic          run;
   logic          src_valid;
   logic          src_ready;
   logic [DW-1:0] src_data;
   logic          src_last;
   logic          c_ack_in;
   logic          s_fin_out;
   logic [AW:0]   frame_len;
   logic          stream_v;
   logic [AW-1:0] stream_a;
   logic [DW-1:0] stream_d;
`ifdef SRC_ERR_EN
   logic          src_err;
`endif

   int checks = 0;
   int errors = 0;

   logic [AW+DW-1:0] exp_wr[$];
   logic [AW:0]      exp_fin[$];

   always #5 clk = ~clk;

   src_ctrl #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .run       (run),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_data  (src_data),
      .src_last  (src_last),
      .c_ack_in  (c_ack_in),
      .s_fin_out (s_fin_out),
      .frame_len (frame_len),
      .stream_v  (stream_v),
      .stream_a  (stream_a),
      .stream_d  (stream_d)
`ifdef SRC_ERR_EN
      ,
      .src_err   (src_err)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every presented write and frame-end must match the head of its queue.
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      if (stream_v === 1'b1) begin
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none at %0t",
                     stream_a, stream_d, $time);
         end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", 64'(stream_a), 64'(e[AW+DW-1:DW]));
            chk("wr_data", 64'(stream_d), 64'(e[DW-1:0]));
         end
      end
      if (s_fin_out === 1'b1) begin
         if (exp_fin.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fin: got frame_len %0d expected no pulse at %0t",
                     frame_len, $time);
         end else begin
            chk("fin_frame_len", 64'(frame_len), 64'(exp_fin.pop_front()));
         end
      end
   end

   // Starts and ends at posedge+1. gaps: idle cycles (i*3+1)%4 before each beat.
   task automatic send_frame(input int n, input int gaps, input int ack_mid,
                             input logic [DW-1:0] base, input int ack_at_fin);
      logic [DW-1:0] d;
      int            exp_len;
      for (int i = 0; i < n; i++) begin
         if (gaps != 0) begin
            for (int g = 0; g < (i * 3 + 1) % 4; g++) begin
               src_valid = 1'b0;
               src_data  = 32'hDEAD_0000 + DW'(g);
               src_last  = 1'b1;
               @(posedge clk); #1;
            end
         end
         d         = base + DW'(i);
         src_valid = 1'b1;
         src_data  = d;
         src_last  = (i == n - 1);
         c_ack_in  = (ack_mid != 0 && i == 1);
         if (i < int'(DEPTH)) exp_wr.push_back({AW'(i), d});
         #1 chk("beat_ready", 64'(src_ready), 64'd1);
         @(posedge clk); #1;
      end
      exp_len   = (n < int'(DEPTH)) ? n : int'(DEPTH);
      exp_fin.push_back((AW + 1)'(exp_len));
      src_valid = 1'b0;
      src_last  = 1'b0;
      src_data  = 32'hBAD0_BAD0;
      c_ack_in  = (ack_at_fin != 0);
      @(negedge clk);
      chk("fin_pulse", 64'(s_fin_out), 64'd1);
      chk("fin_ready", 64'(src_ready), 64'd0);
      @(posedge clk); #1;
      c_ack_in  = 1'b0;
      src_valid = 1'b1;
      src_last  = 1'b1;
      @(negedge clk);
      chk("fin_one_cycle", 64'(s_fin_out), 64'd0);
      chk("wait_frame_len", 64'(frame_len), 64'(exp_len));
      chk("wait_ready", 64'(src_ready), 64'd0);
      @(posedge clk); #1;
      src_valid = 1'b0;
      src_last  = 1'b0;
   endtask

   task automatic do_ack(input int hold);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("wait_hold_ready", 64'(src_ready), 64'd0);
         @(posedge clk); #1;
      end
      c_ack_in = 1'b1;
      @(negedge clk);
      chk("ack_cycle_ready", 64'(src_ready), 64'd0);
      @(posedge clk); #1;
      c_ack_in = 1'b0;
      @(negedge clk);
      chk("ack_release_ready", 64'(src_ready), 64'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      run       = 1'b0;
      src_valid = 1'b0;
      src_data  = '0;
      src_last  = 1'b0;
      c_ack_in  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(src_ready), 64'd1);
      chk("rst_fin", 64'(s_fin_out), 64'd0);
      chk("rst_frame_len", 64'(frame_len), 64'd0);
      chk("rst_stream_v", 64'(stream_v), 64'd0);
      chk("rst_stream_a", 64'(stream_a), 64'd0);
`ifdef SRC_ERR_EN
      chk("rst_src_err", 64'(src_err), 64'd0);
`endif
      @(posedge clk); #1;
      run = 1'b1;
      @(posedge clk); #1;

      send_frame(5, 0, 0, 32'h1000_0000, 0);
      do_ack(3);
      send_frame(4, 1, 0, 32'h2000_0000, 0);
      do_ack(0);
      send_frame(32, 0, 0, 32'h3000_0000, 0);
`ifdef SRC_ERR_EN
      chk("exact_depth_no_err", 64'(src_err), 64'd0);
`endif
      do_ack(1);
      send_frame(40, 0, 0, 32'h4000_0000, 0);
`ifdef SRC_ERR_EN
      chk("trunc_err", 64'(src_err), 64'd1);
`endif
      do_ack(0);
      send_frame(3, 0, 1, 32'h5000_0000, 1);
      do_ack(4);
      send_frame(1, 0, 0, 32'h6000_0000, 0);
      do_ack(0);

      // Partial frame aborted by run=0: writes happen, no frame end follows.
      for (int i = 0; i < 3; i++) begin
         src_valid = 1'b1;
         src_data  = 32'h7000_0000 + DW'(i);
         src_last  = 1'b0;
         exp_wr.push_back({AW'(i), 32'h7000_0000 + DW'(i)});
         #1 chk("abort_beat_ready", 64'(src_ready), 64'd1);
         @(posedge clk); #1;
      end
      src_valid = 1'b0;
      run       = 1'b0;
      #1;
      chk("abort_fin", 64'(s_fin_out), 64'd0);
      chk("abort_frame_len", 64'(frame_len), 64'd0);
      chk("abort_ready", 64'(src_ready), 64'd1);
      chk("abort_addr", 64'(stream_a), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      run = 1'b1;
      @(negedge clk);
      chk("post_abort_frame_len", 64'(frame_len), 64'd0);
      @(posedge clk); #1;
      send_frame(2, 0, 0, 32'h8000_0000, 0);
      do_ack(0);

      repeat (2) @(posedge clk);
      chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
      chk("fin_queue_empty", 64'(exp_fin.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
